// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the operand-read, writeback, scoreboard-allocate and flush
//   signals of the multi-port register file.
//   Signals:
//     raddr      read addresses, port i at [6i+:6]
//     rdata      read data, port i at [DATA_W*i+:DATA_W]
//     rready     per read port: operand available
//     hilo_rdata HI/LO read data (bypassed)
//     we         write enables, higher index = younger = wins
//     waddr      write addresses
//     wdata      write data, 2*DATA_W per port
//     alloc_we   scoreboard allocate enables
//     alloc_addr scoreboard allocate addresses
//     flush      clear all busy bits
//     busy       scoreboard, bit 32 = HI/LO, bit 0 always 0
//   Modports: master (issue stage / testbench), slave (register file).
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int NUM_RD    = 16,
    parameter int NUM_WR    = 4,
    parameter int NUM_ALLOC = 2,
    parameter int DATA_W    = 32
);
    logic [NUM_RD*6-1:0]        raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          rready;
    logic [2*DATA_W-1:0]        hilo_rdata;
    logic [NUM_WR-1:0]          we;
    logic [NUM_WR*6-1:0]        waddr;
    logic [NUM_WR*2*DATA_W-1:0] wdata;
    logic [NUM_ALLOC-1:0]       alloc_we;
    logic [NUM_ALLOC*6-1:0]     alloc_addr;
    logic                       flush;
    logic [32:0]                busy;

    modport master (
        output raddr, we, waddr, wdata, alloc_we, alloc_addr, flush,
        input  rdata, rready, hilo_rdata, busy
    );

    modport slave (
        input  raddr, we, waddr, wdata, alloc_we, alloc_addr, flush,
        output rdata, rready, hilo_rdata, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//   Multi-port GPR file for the multi-issue decode/issue stage, with
//   same-cycle write bypass and a per-register busy scoreboard.
//   Address map (6 bit): 0 = $zero, 1..31 = GPR, 32 = HI/LO, 33..63 unmapped.
//   Ports:
//     clk     clock
//     resetn  asynchronous active-low reset
//     bus     regfile_mp_if.slave (reads, writes, allocs, flush, busy)
//   Configuration macro:
//     REGFILE_HILO_EN  when defined, address 32 is a 2*DATA_W HI/LO register
//                      with its own busy bit; otherwise address 32 behaves
//                      as unmapped and hilo_rdata is 0.
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int NUM_RD    = 16,
    parameter int NUM_WR    = 4,
    parameter int NUM_ALLOC = 2,
    parameter int DATA_W    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    regfile_mp_if.slave   bus
);

`ifdef REGFILE_HILO_EN
    localparam logic [5:0] LP_TOP = 6'd32;
`else
    localparam logic [5:0] LP_TOP = 6'd31;
`endif
    localparam int LP_HW = 2 * DATA_W;

    logic [DATA_W-1:0] r_gpr [1:31];
    logic [32:1]       r_busy;
`ifdef REGFILE_HILO_EN
    logic [LP_HW-1:0]  r_hilo;
`endif

    logic [NUM_RD-1:0][5:0]      w_ra;
    logic [NUM_WR-1:0][5:0]      w_wa;
    logic [NUM_WR-1:0][LP_HW-1:0] w_wd;
    logic [NUM_ALLOC-1:0][5:0]   w_aa;

    logic [32:0]                 w_wr_hit;
    logic [32:0][LP_HW-1:0]      w_wr_data;
    logic [32:0]                 w_alloc_hit;
    logic [32:0][DATA_W-1:0]     w_fwd;
    logic [32:0]                 w_busy_full;
    logic [LP_HW-1:0]            w_hilo_fwd;
    logic [NUM_RD*DATA_W-1:0]    w_rdata;
    logic [NUM_RD-1:0]           w_rready;
    logic                        w_unused;

    assign w_ra = bus.raddr;
    assign w_wa = bus.waddr;
    assign w_wd = bus.wdata;
    assign w_aa = bus.alloc_addr;

    // Per-address write winner: ascending port scan, so the youngest
    // (highest-index) matching port is the last one to assign.
    always_comb begin
        w_wr_hit  = '0;
        w_wr_data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int a = 1; a <= int'(LP_TOP); a++) begin
                if (bus.we[p] && (w_wa[p] == 6'(a))) begin
                    w_wr_hit[a]  = 1'b1;
                    w_wr_data[a] = w_wd[p];
                end
            end
        end
    end

    always_comb begin
        w_alloc_hit = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            for (int a = 1; a <= int'(LP_TOP); a++) begin
                if (bus.alloc_we[k] && (w_aa[k] == 6'(a))) begin
                    w_alloc_hit[a] = 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_HILO_EN
    assign w_hilo_fwd = w_wr_hit[32] ? w_wr_data[32] : r_hilo;
`else
    assign w_hilo_fwd = '0;
`endif

    // Bypassed view of every address; entry 0 stays 0 for $zero.
    always_comb begin
        w_fwd = '0;
        for (int a = 1; a <= 31; a++) begin
            w_fwd[a] = w_wr_hit[a] ? w_wr_data[a][DATA_W-1:0] : r_gpr[a];
        end
        w_fwd[32] = w_hilo_fwd[DATA_W-1:0];
    end

    assign w_busy_full = {r_busy, 1'b0};

    // Unmapped addresses and the reset-held state fall through to the
    // defaults: data 0, ready 1.
    always_comb begin
        w_rdata  = '0;
        w_rready = '1;
        for (int i = 0; i < NUM_RD; i++) begin
            if (resetn && (w_ra[i] != 6'd0) && (w_ra[i] <= LP_TOP)) begin
                w_rdata[DATA_W*i +: DATA_W] = w_fwd[w_ra[i]];
                w_rready[i] = ~w_busy_full[w_ra[i]] | w_wr_hit[w_ra[i]];
            end
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.rready     = w_rready;
    assign bus.hilo_rdata = resetn ? w_hilo_fwd : '0;
    assign bus.busy       = w_busy_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int a = 1; a <= 31; a++) begin
                r_gpr[a] <= '0;
            end
            r_busy <= '0;
`ifdef REGFILE_HILO_EN
            r_hilo <= '0;
`endif
        end else begin
            for (int a = 1; a <= 31; a++) begin
                if (w_wr_hit[a]) begin
                    r_gpr[a] <= w_wr_data[a][DATA_W-1:0];
                end
            end
`ifdef REGFILE_HILO_EN
            if (w_wr_hit[32]) begin
                r_hilo <= w_wr_data[32];
            end
`endif
            // Flush beats alloc; alloc beats a same-cycle writeback because
            // a younger instruction has re-claimed the destination.
            for (int a = 1; a <= int'(LP_TOP); a++) begin
                if (bus.flush) begin
                    r_busy[a] <= 1'b0;
                end else if (w_alloc_hit[a]) begin
                    r_busy[a] <= 1'b1;
                end else if (w_wr_hit[a]) begin
                    r_busy[a] <= 1'b0;
                end
            end
        end
    end

    // GPR entries only use the low half of the write data.
    assign w_unused = ^{w_wr_data, w_wr_hit, w_alloc_hit};

endmodule
